// File: rtl/bus_mem_dev.sv
// Block-RAM responder for the single-word addr/data/we/rd/ack memory bus.
// Clears itself after reset, signals ready with one ack, then serves one request at a time.
module bus_mem_dev #(
    parameter int ADDR_BITS      = 10,
    parameter int LATENCY        = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        we_i,
    input  logic        rd_i,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int                   DEPTH      = 1 << ADDR_BITS;
    localparam logic [31:0]          OOR_DATA   = 32'hDEAD_BEEF;
    localparam logic [ADDR_BITS-1:0] CLEAR_LAST = '1;
    localparam logic [7:0]           LAT_CNT    = 8'(LATENCY);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    logic [31:0]          mem [DEPTH];

    state_t               state_r,     state_n;
    logic [ADDR_BITS-1:0] clear_ptr_r, clear_ptr_n;
    logic [7:0]           cnt_r,       cnt_n;
    logic                 op_we_r,     op_we_n;
    logic                 oor_r,       oor_n;
    logic [ADDR_BITS-1:0] word_r,      word_n;
    logic [31:0]          wdata_r,     wdata_n;
    logic                 ack_r,       ack_n;
    logic                 busy_r,      busy_n;
    logic                 err_r,       err_n;
    logic [31:0]          rdata_r;

    logic [ADDR_BITS-1:0] req_word_s;
    logic                 req_oor_s;
    logic                 mem_we_s;
    logic [ADDR_BITS-1:0] mem_addr_s;
    logic [31:0]          mem_wdata_s;
    logic                 rd_en_s;

    // Request address decode: word index and out-of-range/misalignment detection.
    always_comb begin
        req_word_s = addr_i[ADDR_BITS+1:2];
        req_oor_s  = ((addr_i >> (ADDR_BITS + 2)) != 32'd0) || (addr_i[1:0] != 2'd0);
    end

    // Next-state and next-output logic for the clear/serve sequencer.
    always_comb begin
        state_n     = state_r;
        clear_ptr_n = clear_ptr_r;
        cnt_n       = cnt_r;
        op_we_n     = op_we_r;
        oor_n       = oor_r;
        word_n      = word_r;
        wdata_n     = wdata_r;
        ack_n       = ack_r;
        busy_n      = busy_r;
        err_n       = err_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = word_r;
        mem_wdata_s = wdata_r;
        rd_en_s     = 1'b0;

        case (state_r)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = clear_ptr_r;
                    mem_wdata_s = 32'd0;
                    clear_ptr_n = clear_ptr_r + ADDR_BITS'(1'b1);
                    if (clear_ptr_r == CLEAR_LAST) begin
                        ack_n   = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_CLEAR;
                    end
                end else begin
                    ack_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ack_n = 1'b0;
                if (we_i || rd_i) begin
                    // A simultaneous read+write is served as a write and flagged.
                    op_we_n = we_i;
                    oor_n   = req_oor_s;
                    word_n  = req_word_s;
                    wdata_n = data_i;
                    busy_n  = 1'b1;
                    cnt_n   = LAT_CNT;
                    state_n = ST_WAIT;
                    if (we_i && rd_i) begin
                        err_n = 1'b1;
                    end else begin
                        err_n = err_r;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_n = ST_ACK;
                end else begin
                    cnt_n = cnt_r - 8'd1;
                end
            end
            ST_ACK: begin
                ack_n   = 1'b1;
                state_n = ST_HOLD;
                if (oor_r) begin
                    err_n = 1'b1;
                end else begin
                    err_n = err_r;
                end
                if (op_we_r) begin
                    mem_we_s = !oor_r;
                end else begin
                    rd_en_s = 1'b1;
                end
            end
            ST_HOLD: begin
                ack_n = 1'b0;
                if (!we_i && !rd_i) begin
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n = ST_CLEAR;
                busy_n  = 1'b1;
                ack_n   = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers; reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_CLEAR;
            clear_ptr_r <= '0;
            cnt_r       <= 8'd0;
            op_we_r     <= 1'b0;
            oor_r       <= 1'b0;
            word_r      <= '0;
            wdata_r     <= 32'd0;
            ack_r       <= 1'b0;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            clear_ptr_r <= clear_ptr_n;
            cnt_r       <= cnt_n;
            op_we_r     <= op_we_n;
            oor_r       <= oor_n;
            word_r      <= word_n;
            wdata_r     <= wdata_n;
            ack_r       <= ack_n;
            busy_r      <= busy_n;
            err_r       <= err_n;
        end
    end

    // Single-port RAM write; contents are left alone while rst is held.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Registered read port; data is held until the next read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'd0;
        end else if (rd_en_s) begin
            rdata_r <= oor_r ? OOR_DATA : mem[word_r];
        end
    end

    assign data_o = rdata_r;
    assign ack_o  = ack_r;
    assign busy_o = busy_r;
    assign err_o  = err_r;

endmodule
